// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side branch predictor for the RV32I core. A direct-mapped branch
// target buffer holds a tag, a target and a valid bit per entry, with a 2-bit
// saturating direction counter alongside. Fetch looks it up combinationally
// every cycle; execute writes back every resolved branch/jump.
//
// Optional feature (macro GSHARE_EN): a global history register is XORed
// into the index for both lookup and update. The history seen at lookup is
// exported on predHist and must come back on updateHist with the resolution.
// With the macro undefined the table is purely PC indexed and the history
// ports do not exist.
//
// Ports:
//   clk              in   core clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   fetchPC          in   PC being fetched this cycle
//   predTaken        out  predict a redirect to predTarget
//   predTarget       out  predicted target (0 on a BTB miss)
//   updateValid      in   execute reports a resolved control transfer
//   updatePC         in   PC of the resolved instruction
//   updateIsJump     in   JAL/JALR (unconditional)
//   updateTaken      in   resolved direction
//   updateTarget     in   resolved target address
//   updateMisaligned in   resolution raised a misaligned-target exception
//   flush            in   invalidate every entry (fence.i, context change)
//   predHist         out  (GSHARE_EN) global history used for this lookup
//   updateHist       in   (GSHARE_EN) history carried with the resolution
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8,
  parameter int XLEN     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [XLEN-1:0]             fetchPC,
  output logic                        predTaken,
  output logic [XLEN-1:0]             predTarget,
  input  logic                        updateValid,
  input  logic [XLEN-1:0]             updatePC,
  input  logic                        updateIsJump,
  input  logic                        updateTaken,
  input  logic [XLEN-1:0]             updateTarget,
  input  logic                        updateMisaligned,
  input  logic                        flush
`ifdef GSHARE_EN
  ,
  output logic [$clog2(ENTRIES)-1:0]  predHist,
  input  logic [$clog2(ENTRIES)-1:0]  updateHist
`endif
);

  localparam int IDX = $clog2(ENTRIES);

  // ---------------------------------------------------------------------------
  // Counter helpers
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr        [ENTRIES];
  logic [TAG_BITS-1:0] tag_mem   [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];

`ifdef GSHARE_EN
  logic [IDX-1:0]     ghr;
`endif

  // ---------------------------------------------------------------------------
  // Lookup (combinational from the flops, no bypass of a same-cycle update)
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]      fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic                fetch_hit;

`ifdef GSHARE_EN
  assign fetch_idx = fetchPC[IDX+1:2] ^ ghr;
  assign predHist  = ghr;
`else
  assign fetch_idx = fetchPC[IDX+1:2];
`endif
  assign fetch_tag = fetchPC[TAG_BITS+IDX+1:IDX+2];
  assign fetch_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

  assign predTaken  = fetch_hit && ctr[fetch_idx][1];
  assign predTarget = fetch_hit ? target_mem[fetch_idx] : '0;

  // ---------------------------------------------------------------------------
  // Update decode
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_en;
  logic                upd_hit;
  logic                upd_alloc;

`ifdef GSHARE_EN
  assign upd_idx = updatePC[IDX+1:2] ^ updateHist;
`else
  assign upd_idx = updatePC[IDX+1:2];
`endif
  assign upd_tag = updatePC[TAG_BITS+IDX+1:IDX+2];

  // A misaligned resolution never trains the predictor.
  assign upd_en    = updateValid && !updateMisaligned;
  assign upd_hit   = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  // Only transfers that actually redirect are worth a BTB slot.
  assign upd_alloc = !upd_hit && (updateTaken || updateIsJump);

  // ---------------------------------------------------------------------------
  // State update; flush outranks a simultaneous resolution
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]        <= 2'b01;
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
      end
`ifdef GSHARE_EN
      ghr <= '0;
`endif
    end else if (flush) begin
      valid <= '0;
`ifdef GSHARE_EN
      ghr <= '0;
`endif
    end else if (upd_en) begin
      if (upd_hit) begin
        if (updateIsJump) begin
          ctr[upd_idx]        <= 2'b11;
          target_mem[upd_idx] <= updateTarget;
        end else if (updateTaken) begin
          ctr[upd_idx]        <= sat_inc(ctr[upd_idx]);
          target_mem[upd_idx] <= updateTarget;
        end else begin
          // Not-taken keeps the last known target for when it flips back.
          ctr[upd_idx] <= sat_dec(ctr[upd_idx]);
        end
      end else if (upd_alloc) begin
        valid[upd_idx]      <= 1'b1;
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= updateTarget;
        // A fresh conditional starts weakly taken so one miss can demote it.
        ctr[upd_idx]        <= updateIsJump ? 2'b11 : 2'b10;
      end
`ifdef GSHARE_EN
      // History tracks conditional outcomes only.
      if (!updateIsJump) begin
        ghr <= {ghr[IDX-2:0], updateTaken};
      end
`endif
    end
  end

endmodule
